// File: rtl/dmem_pkg.sv
// Shared types and address-decode helper for the data-memory responder.
// Also reused by anything that needs the same RAM/MMIO address map.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_NONE
  } region_e;

  localparam logic [31:0] LED_OFS = 32'd0;
  localparam logic [31:0] SW_OFS  = 32'd4;

  // Word-granular decode: the two low address bits never take part.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    logic [31:0] word_a;
    logic [31:0] led_a;
    logic [31:0] sw_a;
    word_a = {addr[31:2], 2'b00};
    led_a  = (mmio_base + LED_OFS) & 32'hFFFF_FFFC;
    sw_a   = (mmio_base + SW_OFS) & 32'hFFFF_FFFC;
    if (word_a < ram_bytes) begin
      return REG_RAM;
    end else if (word_a == led_a) begin
      return REG_LED;
    end else if (word_a == sw_a) begin
      return REG_SW;
    end
    return REG_NONE;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word array with per-byte write enables, synchronous write and combinational
// read; sized by DEPTH_WORDS so it can also back instruction memory.
module dmem_ram #(
  parameter int DEPTH_WORDS = 2048,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target: RAM plus LED/switch MMIO, answering
// each accepted request with a one-cycle strobe after a fixed wait.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [7:0]  sw,
  output logic [7:0]  led
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; rsp_valid is a one-cycle strobe with no back-pressure.

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_ni = rst_sync_q[1];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_meta_q, sw_meta_d;
  logic [7:0]  sw_sync_q, sw_sync_d;

  region_e     region;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] rd_word;
  logic        rd_err;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be_q),
    .addr  (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    region = decode_region(addr_q, RAM_BYTES, MMIO_BASE);
  end

  // Response payload; the write side effects land one cycle earlier.
  always_comb begin
    rd_word = 32'd0;
    rd_err  = 1'b0;
    case (region)
      REG_RAM: rd_word = ram_rdata;
      REG_LED: rd_word = {24'd0, led_q};
      REG_SW: begin
        rd_word = {24'd0, sw_sync_q};
        rd_err  = we_q;
      end
      default: rd_err = 1'b1;
    endcase
    if (we_q) rd_word = 32'd0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    led_d       = led_q;
    ram_we      = 1'b0;
    sw_meta_d   = sw;
    sw_sync_d   = sw_meta_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          ram_we  = we_q && (region == REG_RAM);
          if (we_q && (region == REG_LED) && be_q[0]) led_d = wdata_q[7:0];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rd_word;
        rsp_err_d   = rd_err;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      led_q       <= 8'd0;
      sw_meta_q   <= 8'd0;
      sw_sync_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      led_q       <= led_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
    end
  end

  // Ready stays low until the internal reset has released, so no handshake is lost.
  assign req_ready = req_ready_q & rst_ni;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases with literal results, a reset
// mid-transaction, then randomized traffic against a behavioural model.
module tb_dmem_responder;

  localparam int          DEPTH     = 2048;
  localparam int          LAT       = 4;
  localparam logic [31:0] MMIO      = 32'h1000_0000;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  sw, led;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MMIO_BASE(MMIO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sw        (sw),
    .led       (led)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [31:0] mem_m [int unsigned];
  logic [7:0]  led_m = 8'h00;
  logic [31:0] exp_q[$];
  logic        err_q[$];
  bit          pend = 1'b0;
  int          due = 0;
  int          settle = 1;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  bit          p_lit;
  logic [31:0] p_lit_rd;
  bit          p_lit_err;
  bit          lit_en = 1'b0;
  logic [31:0] lit_rd = 32'd0;
  bit          lit_err = 1'b0;

  // Applies the pending access to the model and queues its response.
  task automatic model_commit();
    int unsigned w;
    logic [31:0] cur, word_a, rd;
    bit          err;
    w      = int'(p_addr >> 2);
    word_a = p_addr & 32'hFFFF_FFFC;
    rd     = 32'd0;
    err    = 1'b0;
    if (word_a < RAM_BYTES) begin
      cur = mem_m.exists(w) ? mem_m[w] : 32'hxxxx_xxxx;
      if (p_we) begin
        for (int b = 0; b < 4; b++)
          if (p_be[b]) cur[8*b +: 8] = p_wdata[8*b +: 8];
        mem_m[w] = cur;
      end else begin
        rd = cur;
      end
    end else if (word_a == MMIO) begin
      if (p_we && p_be[0]) led_m = p_wdata[7:0];
      if (!p_we) rd = {24'd0, led_m};
    end else if (word_a == MMIO + 32'd4) begin
      if (p_we) err = 1'b1;
      else      rd = {24'd0, sw};
    end else begin
      err = 1'b1;
    end
    exp_q.push_back(rd);
    err_q.push_back(err);
  endtask

  always @(negedge clk) begin
    logic [31:0] e_rd;
    logic        e_err;
    bit          exp_v;
    if (!rst_n) begin
      pend   = 1'b0;
      led_m  = 8'h00;
      settle = 1;
      exp_q.delete();
      err_q.delete();
      chk("rsp_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
      chk("led_in_reset", {24'd0, led}, 32'd0);
    end else begin
      if (pend && cyc == due - 1) model_commit();
      chk("led", {24'd0, led}, {24'd0, led_m});
      exp_v = pend && (cyc == due);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
      if (exp_v) begin
        pend  = 1'b0;
        e_rd  = exp_q.pop_front();
        e_err = err_q.pop_front();
        if (!$isunknown(e_rd)) chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
        if (p_lit) begin
          chk("lit_rdata", rsp_rdata, p_lit_rd);
          chk("lit_err", {31'd0, rsp_err}, {31'd0, p_lit_err});
        end
      end
      if (settle > 0) begin
        if (req_ready) begin
          settle = 0;
        end else if (settle >= 5) begin
          n_cmp++;
          n_fail++;
          $display("FAIL ready_after_reset: req_ready 0 for 5 cycles, required 1");
          settle = 0;
        end else begin
          settle++;
        end
      end
      if (settle == 0) begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, !pend});
        if (req_valid && !pend) begin
          pend      = 1'b1;
          due       = cyc + LAT + 2;
          p_we      = req_we;
          p_addr    = req_addr;
          p_wdata   = req_wdata;
          p_be      = req_be;
          p_lit     = lit_en;
          p_lit_rd  = lit_rd;
          p_lit_err = lit_err;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int gap);
    bit got;
    got       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: req_ready stayed 0, required 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    lit_en = 1'b0;
    if (gap > 0) begin
      req_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_lit(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] rd, input bit err);
    lit_en  = 1'b1;
    lit_rd  = rd;
    lit_err = err;
    do_req(we, addr, wdata, be, 1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 60 && pend; i++) @(negedge clk);
    if (pend) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: response still pending after 60 cycles, required none");
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k, r;
    k = $urandom_range(0, 9);
    if (k <= 5) begin
      r = $urandom_range(0, 18);
      if (r == 16)      r = 16;
      else if (r == 17) r = 32;
      else if (r == 18) r = DEPTH - 1;
      return (32'(r) << 2) | 32'($urandom_range(0, 3));
    end
    if (k == 6) return MMIO;
    if (k == 7) return MMIO + 32'd4;
    if (k == 8) return RAM_BYTES + (32'($urandom_range(0, 255)) << 2);
    return 32'h2000_0000 | 32'($urandom_range(0, 65535));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    sw        = 8'h00;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_lit(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    do_lit(1'b0, 32'h40, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    do_lit(1'b1, 32'h40, 32'h0000_1100, 4'b0010, 32'd0, 1'b0);
    do_lit(1'b0, 32'h40, 32'd0, 4'h0, 32'hDEAD_11EF, 1'b0);
    do_lit(1'b1, MMIO, 32'h0000_00A5, 4'b0001, 32'd0, 1'b0);
    do_lit(1'b0, MMIO, 32'd0, 4'h0, 32'h0000_00A5, 1'b0);
    drain();
    sw = 8'h3C;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    do_lit(1'b0, MMIO + 32'd4, 32'd0, 4'h0, 32'h0000_003C, 1'b0);
    do_lit(1'b1, MMIO + 32'd4, 32'h0000_00FF, 4'hF, 32'd0, 1'b1);
    do_lit(1'b0, MMIO + 32'd4, 32'd0, 4'h0, 32'h0000_003C, 1'b0);
    do_lit(1'b0, 32'h0000_2000, 32'd0, 4'h0, 32'd0, 1'b1);
    do_lit(1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF, 32'd0, 1'b1);
    do_lit(1'b0, 32'h40, 32'd0, 4'h0, 32'hDEAD_11EF, 1'b0);
    do_lit(1'b1, RAM_BYTES - 32'd4, 32'h1234_5678, 4'hF, 32'd0, 1'b0);
    do_lit(1'b0, RAM_BYTES - 32'd4, 32'd0, 4'h0, 32'h1234_5678, 1'b0);
    do_lit(1'b0, RAM_BYTES, 32'd0, 4'h0, 32'd0, 1'b1);
    do_lit(1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);
    do_lit(1'b0, 32'h43, 32'd0, 4'h0, 32'hDEAD_11EF, 1'b0);
    do_lit(1'b1, 32'h80, 32'h0BAD_F00D, 4'hF, 32'd0, 1'b0);
    drain();

    // Reset during WAIT of a store, with the request line held high throughout.
    do_req(1'b1, 32'h80, 32'h1111_1111, 4'hF, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    req_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_lit(1'b0, 32'h80, 32'd0, 4'h0, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    chk("led_after_reset", {24'd0, led}, 32'd0);
    drain();

    for (int w = 0; w < 16; w++) do_req(1'b1, 32'(w) << 2, $urandom, 4'hF, $urandom_range(0, 1));
    do_req(1'b1, RAM_BYTES - 32'd4, $urandom, 4'hF, 0);
    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2));
    end
    drain();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder for the RV32I pipeline core; the core's load/store unit is the initiator, this block is the target.
- Accepts one request at a time over a valid/ready handshake. Serves word-addressed RAM and two MMIO registers (LED out, switch in).
- Returns a single-cycle response after a programmable latency, so the pipeline's load-stall logic is exercised with realistic wait states.

Parameters:
- DEPTH_WORDS, 2048, RAM size in 32-bit words; RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1.
- LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..15.
- MMIO_BASE, 32'h1000_0000, byte address of the LED register; the switch register is at MMIO_BASE+4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored, byte lanes selected by req_be.
- req_wdata  in  32  store data, already lane-aligned.
- req_be  in  4  byte enables for stores; ignored for loads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data, full word; 0 on stores and errors.
- rsp_err  out  1  access fault, qualified by rsp_valid.
- sw  in  8  board switches, asynchronous.
- led  out  8  board LEDs.

Behaviour:
- Reset (async assert, sync deassert inside block): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led=0, switch synchronizer=0. RAM contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata/be, load cnt=LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. When cnt==0, perform the access and go to RESP; otherwise decrement cnt.
  - RESP: rsp_valid=1 for exactly this cycle, req_ready=0, then go to IDLE.
- Result: with LATENCY=L, rsp_valid asserts L+1 cycles after the accept edge. The next accept can occur the cycle after RESP. No back-to-back accept.
- The access is committed on the WAIT->RESP edge. RAM writes apply per-byte under be; loads read the post-reset or latest written value.
- Decode uses the latched address:
  - RAM hit: addr < DEPTH_WORDS*4. Word index is addr[31:2].
  - LED hit: addr == MMIO_BASE. Store with be[0] writes led <= wdata[7:0]. Load returns {24'b0, led}.
  - SW hit: addr == MMIO_BASE+4. Load returns {24'b0, sw_sync}. Store sets err=1 and has no side effect.
  - Any other address: err=1, rdata=0, no side effect.
- Stores return rsp_valid with rdata=0 and err=0 unless faulted.
- Store with be=4'b0000 is a legal no-op response, err=0.
- sw passes through a 2-flop synchronizer; a load sees a switch change no earlier than 2 cycles later.
- req_valid is ignored outside IDLE. The initiator must hold the request until accepted; this block does not buffer a second request.
- Reset asserted mid-transaction drops the pending access: no RAM or LED write, no response.
- rsp_rdata and rsp_err hold their last values when rsp_valid=0. Checkers must sample them only when rsp_valid=1.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE, WAIT, RESP);
  - MMIO offset constants LED_OFS=0 and SW_OFS=4;
  - a region-decode enum (REG_RAM, REG_LED, REG_SW, REG_NONE).
- One sub-module, dmem_ram: a byte-enable synchronous-write, asynchronous-read word array of DEPTH_WORDS entries. It is instantiated once and is reusable as instruction memory.

Test Plan:
- Reset, then store 32'hDEAD_BEEF be=4'hF to addr 0x40, then load 0x40 -> store rsp err=0; load rsp_rdata=32'hDEAD_BEEF, err=0. Each rsp_valid appears LATENCY+1 cycles after accept.
- Store 32'h0000_1100 be=4'b0010 to 0x40 over existing 32'hDEAD_BEEF, then load 0x40 -> rsp_rdata=32'hDEAD_11EF.
- Store 32'h0000_00A5 to MMIO_BASE -> led=8'hA5 the cycle rsp_valid rises. Load MMIO_BASE -> rdata=32'h0000_00A5.
- Drive sw=8'h3C, wait 3 cycles, load MMIO_BASE+4 -> rdata=32'h0000_003C. Store to MMIO_BASE+4 -> err=1, and a following load still returns 32'h0000_003C.
- Load 32'h0000_2000 with DEPTH_WORDS=2048 -> err=1, rdata=0. Store to 32'h2000_0000 -> err=1. A following load of 0x40 is unaffected.
- With LATENCY=4: hold req_valid high continuously, then pulse rst_n low during WAIT of a store to 0x80 -> no rsp_valid, mem[0x80] unchanged, led=0. After release, req_ready=1 and the next request completes in 5 cycles.
